// File: rtl/lc3_mem_ctrl_if.sv
// lc3_mem_ctrl_if: datapath, memory, keyboard and display signals of lc3_mem_ctrl; master drives requests/responses, slave is the controller
interface lc3_mem_ctrl_if;
  logic [15:0] bus_in;
  logic        ld_mar;
  logic        ld_mdr;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mdr;
  logic        ready;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        ddr_valid;
  logic [7:0]  ddr_data;
  logic        ddr_ack;
  modport master (
    output bus_in, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ack, kb_valid, kb_data, ddr_ack,
    input  mdr, ready, err, mem_req, mem_we, mem_addr, mem_wdata, ddr_valid, ddr_data
  );
  modport slave (
    input  bus_in, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ack, kb_valid, kb_data, ddr_ack,
    output mdr, ready, err, mem_req, mem_we, mem_addr, mem_wdata, ddr_valid, ddr_data
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR access controller decoding MAR to memory (req/ack) or KBSR/KBDR/DSR/DDR; ports clk, rst, bus (lc3_mem_ctrl_if.slave)
module lc3_mem_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input logic           clk,
  input logic           rst,
  lc3_mem_ctrl_if.slave bus
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {IDLE, MEM, IOW, DONE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   mar_q, mar_d, mdr_q, mdr_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d, ready_q, ready_d, err_q, err_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic          ddr_valid_q, ddr_valid_d, kb_full_q, kb_full_d;
  logic [7:0]    ddr_data_q, ddr_data_d, kbdr_q, kbdr_d;
  logic          is_io, ddr_busy, ddr_wr, kbdr_rd, kb_load, timeout;
  logic [1:0]    sel;
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    rw_d        = rw_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ddr_wr      = 1'b0;
    kbdr_rd     = 1'b0;
    sel         = mar_q[2:1];
    is_io       = mar_q[15:3] == 13'h1FC0 && !mar_q[0];
    // an acknowledge on this edge frees the display, so a write here still lands
    ddr_busy    = ddr_valid_q & ~bus.ddr_ack;
    timeout     = cnt_q == CW'(WAIT_MAX - 1);
    case (state_q)
      IDLE: begin
        mar_d = bus.ld_mar ? bus.bus_in : mar_q;
        mdr_d = bus.ld_mdr && !bus.mio_en ? bus.bus_in : mdr_q;
        if (bus.mio_en) begin
          rw_d  = bus.r_w;
          cnt_d = '0;
          if (!is_io) begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.r_w;
            mem_addr_d  = mar_q;
            mem_wdata_d = mdr_q;
          end else if (bus.r_w && sel == 2'd3 && ddr_busy) begin
            state_d = IOW;
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            ddr_wr  = bus.r_w && sel == 2'd3;
            kbdr_rd = !bus.r_w && sel == 2'd1;
            if (!bus.r_w)
              mdr_d = sel == 2'd0 ? {kb_full_q, 15'b0} :
                      sel == 2'd1 ? {8'h00, kbdr_q} :
                      sel == 2'd2 ? {~ddr_valid_q, 15'b0} : 16'h0000;
          end
        end
      end
      MEM: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_ack || timeout) begin
          state_d   = DONE;
          ready_d   = 1'b1;
          err_d     = !bus.mem_ack;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mdr_d     = rw_q ? mdr_q : bus.mem_ack ? bus.mem_rdata : 16'h0000;
        end
      end
      IOW: begin
        cnt_d = cnt_q + 1'b1;
        if (!ddr_busy || timeout) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = ddr_busy;
          ddr_wr  = !ddr_busy;
        end
      end
      DONE: state_d = IDLE;
    endcase
    ddr_valid_d = ddr_wr | (ddr_valid_q & ~bus.ddr_ack);
    ddr_data_d  = ddr_wr ? mdr_q[7:0] : ddr_data_q;
    // a KBDR read frees the buffer on the same edge, so a simultaneous strobe is accepted
    kb_load     = bus.kb_valid & (~kb_full_q | kbdr_rd);
    kbdr_d      = kb_load ? bus.kb_data : kbdr_q;
    kb_full_d   = kb_load | (kb_full_q & ~kbdr_rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      rw_q        <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ddr_valid_q <= 1'b0;
      ddr_data_q  <= '0;
      kb_full_q   <= 1'b0;
      kbdr_q      <= '0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      rw_q        <= rw_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ddr_valid_q <= ddr_valid_d;
      ddr_data_q  <= ddr_data_d;
      kb_full_q   <= kb_full_d;
      kbdr_q      <= kbdr_d;
    end
  end
  assign bus.mdr       = mdr_q;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ddr_valid = ddr_valid_q;
  assign bus.ddr_data  = ddr_data_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: self-checking bench for lc3_mem_ctrl with vector table, corner sequences and a random transaction-level model
module tb_lc3_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  int last_reqs;
  logic prev_ready = 1'b0;
  logic [15:0] resp_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  lc3_mem_ctrl_if b();
  lc3_mem_ctrl #(.WAIT_MAX(4)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [15:0] wd;
    int          mdly;
    logic [15:0] emdr;
    int          elat;
    logic        edv;
    logic [7:0]  edd;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && b.ready && prev_ready) begin
      errs++;
      $display("FAIL ready_twice: got 1 expected 0");
    end
    if (!rst && b.err && !b.ready) begin
      errs++;
      $display("FAIL err_alone: got err=1 ready=0 expected err only with ready");
    end
    prev_ready <= b.ready;
  end
  task automatic access(input logic [15:0] a, input logic rw, input logic [15:0] wd, input int mdly,
                        input int ddly, input logic kbv, input logic [7:0] kbd,
                        output logic [15:0] rd, output logic e, output int lat);
    int reqs;
    reqs = 0;
    lat = 0;
    rd = 'x;
    e = 1'bx;
    @(negedge clk);
    b.ld_mar = 1'b1;
    b.bus_in = a;
    @(negedge clk);
    b.ld_mar = 1'b0;
    b.ld_mdr = rw;
    b.bus_in = wd;
    @(negedge clk);
    b.ld_mdr = 1'b0;
    b.mio_en = 1'b1;
    b.r_w = rw;
    b.kb_valid = kbv;
    b.kb_data = kbd;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      @(negedge clk);
      b.kb_valid = 1'b0;
      b.mem_ack = 1'b0;
      b.ddr_ack = 1'b0;
      if (b.ready) begin
        lat = t;
        rd = b.mdr;
        e = b.err;
        b.mio_en = 1'b0;
      end else begin
        if (b.mem_req) begin
          reqs++;
          chk("mem_addr", b.mem_addr, a);
          chk("mem_we", b.mem_we, rw);
          if (rw) chk("mem_wdata", b.mem_wdata, wd);
          if (reqs == mdly + 1) begin
            b.mem_ack = 1'b1;
            b.mem_rdata = resp_mem.exists(b.mem_addr) ? resp_mem[b.mem_addr] : b.mem_addr ^ 16'h5A5A;
            if (b.mem_we) resp_mem[b.mem_addr] = b.mem_wdata;
          end
        end
        if (t == ddly + 1) b.ddr_ack = 1'b1;
      end
    end
    if (lat == 0) chk("ready_wait", lat, 32'd1);
    b.mio_en = 1'b0;
    last_reqs = reqs;
  endtask
  task automatic run(input string n, input logic [15:0] a, input logic rw, input logic [15:0] wd,
                     input int mdly, input int ddly, input logic kbv, input logic [7:0] kbd,
                     input logic [15:0] emdr, input logic eerr, input int elat);
    logic [15:0] rd;
    logic e;
    int lat;
    access(a, rw, wd, mdly, ddly, kbv, kbd, rd, e, lat);
    chk({n, "_mdr"}, rd, emdr);
    chk({n, "_err"}, e, eerr);
    chk({n, "_lat"}, lat, elat);
  endtask
  task automatic kb(input logic [7:0] d);
    @(negedge clk);
    b.kb_valid = 1'b1;
    b.kb_data = d;
    @(negedge clk);
    b.kb_valid = 1'b0;
  endtask
  task automatic dack();
    @(negedge clk);
    b.ddr_ack = 1'b1;
    @(negedge clk);
    b.ddr_ack = 1'b0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] a, wd, emdr;
    logic rw, io, m_kbf, m_dv;
    logic [7:0] m_kbd, m_dd, d;
    int op, mdly, ddly, elat;
    b.bus_in = '0; b.ld_mar = 0; b.ld_mdr = 0; b.mio_en = 0; b.r_w = 0;
    b.mem_rdata = '0; b.mem_ack = 0; b.kb_valid = 0; b.kb_data = '0; b.ddr_ack = 0;
    resp_mem[16'h3000] = 16'hBEEF;
    ref_mem[16'h3000] = 16'hBEEF;
    tbl[0]  = '{16'h3000, 1'b0, 16'h0000, 3, 16'hBEEF, 5, 1'b0, 8'h00};
    tbl[1]  = '{16'h4000, 1'b1, 16'h1234, 1, 16'h1234, 3, 1'b0, 8'h00};
    tbl[2]  = '{16'h4000, 1'b0, 16'h0000, 0, 16'h1234, 2, 1'b0, 8'h00};
    tbl[3]  = '{16'hFE00, 1'b0, 16'h0000, 0, 16'h0000, 1, 1'b0, 8'h00};
    tbl[4]  = '{16'hFE04, 1'b0, 16'h0000, 0, 16'h8000, 1, 1'b0, 8'h00};
    tbl[5]  = '{16'hFE06, 1'b0, 16'h0000, 0, 16'h0000, 1, 1'b0, 8'h00};
    tbl[6]  = '{16'hFE06, 1'b1, 16'h0058, 0, 16'h0058, 1, 1'b1, 8'h58};
    tbl[7]  = '{16'hFE04, 1'b0, 16'h0000, 0, 16'h0000, 1, 1'b1, 8'h58};
    tbl[8]  = '{16'hFE00, 1'b1, 16'h00FF, 0, 16'h00FF, 1, 1'b1, 8'h58};
    tbl[9]  = '{16'hFE00, 1'b0, 16'h0000, 0, 16'h0000, 1, 1'b1, 8'h58};
    tbl[10] = '{16'h1234, 1'b0, 16'h0000, 2, 16'h486E, 4, 1'b1, 8'h58};
    tbl[11] = '{16'hFE01, 1'b0, 16'h0000, 0, 16'hA45B, 2, 1'b1, 8'h58};
    repeat (2) @(negedge clk);
    chk("rst_mdr", b.mdr, 16'h0);
    chk("rst_ready", b.ready, 1'b0);
    chk("rst_err", b.err, 1'b0);
    chk("rst_mem_req", b.mem_req, 1'b0);
    chk("rst_mem_we", b.mem_we, 1'b0);
    chk("rst_mem_addr", b.mem_addr, 16'h0);
    chk("rst_mem_wdata", b.mem_wdata, 16'h0);
    chk("rst_ddr_valid", b.ddr_valid, 1'b0);
    chk("rst_ddr_data", b.ddr_data, 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].a, tbl[i].rw, tbl[i].wd, tbl[i].mdly, -1, 1'b0, 8'h0,
          tbl[i].emdr, 1'b0, tbl[i].elat);
      chk($sformatf("tbl%0d_dv", i), b.ddr_valid, tbl[i].edv);
      chk($sformatf("tbl%0d_dd", i), b.ddr_data, tbl[i].edd);
    end
    kb(8'h41);
    run("kbsr_full", 16'hFE00, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h8000, 1'b0, 1);
    kb(8'h42);
    run("kbdr_rd", 16'hFE02, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h0041, 1'b0, 1);
    run("kbsr_empty", 16'hFE00, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h0000, 1'b0, 1);
    kb(8'h43);
    run("kbdr_race", 16'hFE02, 1'b0, 16'h0, 0, -1, 1'b1, 8'h44, 16'h0043, 1'b0, 1);
    run("kbsr_race", 16'hFE00, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h8000, 1'b0, 1);
    run("kbdr_new", 16'hFE02, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h0044, 1'b0, 1);
    run("kbsr_end", 16'hFE00, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h0000, 1'b0, 1);
    run("ddr_stall", 16'hFE06, 1'b1, 16'h0059, -1, 2, 1'b0, 8'h0, 16'h0059, 1'b0, 4);
    chk("ddr_stall_dv", b.ddr_valid, 1'b1);
    chk("ddr_stall_dd", b.ddr_data, 8'h59);
    run("ddr_tmo", 16'hFE06, 1'b1, 16'h005A, -1, -1, 1'b0, 8'h0, 16'h005A, 1'b1, 5);
    chk("ddr_tmo_dv", b.ddr_valid, 1'b1);
    chk("ddr_tmo_dd", b.ddr_data, 8'h59);
    dack();
    chk("ddr_acked_dv", b.ddr_valid, 1'b0);
    run("dsr_free", 16'hFE04, 1'b0, 16'h0, 0, -1, 1'b0, 8'h0, 16'h8000, 1'b0, 1);
    run("mem_tmo", 16'h3005, 1'b0, 16'h0, -1, -1, 1'b0, 8'h0, 16'h0000, 1'b1, 5);
    chk("mem_tmo_reqs", last_reqs, 32'd4);
    @(negedge clk);
    chk("mem_tmo_req_low", b.mem_req, 1'b0);
    @(negedge clk);
    b.ld_mar = 1'b1;
    b.bus_in = 16'h3000;
    @(negedge clk);
    b.ld_mar = 1'b0;
    b.mio_en = 1'b1;
    b.r_w = 1'b0;
    @(negedge clk);
    chk("midrst_req_pre", b.mem_req, 1'b1);
    rst = 1'b1;
    b.mio_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req", b.mem_req, 1'b0);
    chk("midrst_ready", b.ready, 1'b0);
    chk("midrst_mdr", b.mdr, 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_noready", b.ready, 1'b0);
    end
    run("after_rst", 16'h3001, 1'b0, 16'h0, 1, -1, 1'b0, 8'h0, 16'h6A5B, 1'b0, 3);
    m_kbf = 1'b0; m_kbd = 8'h0; m_dv = 1'b0; m_dd = 8'h0;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        d = 8'($urandom);
        kb(d);
        if (!m_kbf) begin
          m_kbf = 1'b1;
          m_kbd = d;
        end
      end else if (op == 1) begin
        dack();
        m_dv = 1'b0;
      end else begin
        io = 1'($urandom_range(0, 1));
        a = io ? {13'h1FC0, 2'($urandom_range(0, 3)), 1'b0} : 16'h3000 + 16'($urandom_range(0, 7));
        rw = 1'($urandom_range(0, 1));
        wd = 16'($urandom);
        mdly = $urandom_range(0, 3);
        ddly = -1;
        elat = 1;
        emdr = rw ? wd : 16'h0000;
        if (!io) begin
          elat = mdly + 2;
          if (rw) ref_mem[a] = wd;
          else emdr = ref_mem.exists(a) ? ref_mem[a] : a ^ 16'h5A5A;
        end else if (rw) begin
          if (a[2:1] == 2'd3) begin
            if (m_dv) begin
              ddly = $urandom_range(0, 2);
              elat = ddly + 2;
            end
            m_dv = 1'b1;
            m_dd = wd[7:0];
          end
        end else begin
          case (a[2:1])
            2'd0: emdr = {m_kbf, 15'b0};
            2'd1: begin
              emdr = {8'h00, m_kbd};
              m_kbf = 1'b0;
            end
            2'd2: emdr = {~m_dv, 15'b0};
            default: emdr = 16'h0000;
          endcase
        end
        run($sformatf("rnd%0d", i), a, rw, wd, mdly, ddly, 1'b0, 8'h0, emdr, 1'b0, elat);
        chk("rnd_dv", b.ddr_valid, m_dv);
        chk("rnd_dd", b.ddr_data, m_dd);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory/IO access controller for the LC-3 datapath; it consumes the effective addresses produced by the address-select adder. It holds MAR and MDR and decodes MAR into main memory or the memory-mapped keyboard/display registers. Memory accesses use a req/ack handshake, and completion is returned to the control FSM as the LC-3 `R` (ready) signal. It sits between the datapath bus and external memory, the keyboard and the display.

## Interface
- `WAIT_MAX`, default 255: maximum cycles an access may wait for `mem_ack` or display free before abort.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `bus_in  in  16`: datapath bus (effective address or store data).
- `ld_mar  in  1`: load MAR from `bus_in`.
- `ld_mdr  in  1`: load MDR from `bus_in`. Ignored when `mio_en`=1.
- `mio_en  in  1`: request access at MAR. Held by the control FSM until `ready`.
- `r_w  in  1`: 0 read, 1 write; sampled at access start.
- `mdr  out  16`: MDR contents.
- `ready  out  1`: one-cycle completion pulse.
- `err  out  1`: high with `ready` when access timed out.
- `mem_req  out  1`, `mem_we  out  1`, `mem_addr  out  16`, `mem_wdata  out  16`: memory request.
- `mem_rdata  in  16`, `mem_ack  in  1`: memory response.
- `kb_valid  in  1`, `kb_data  in  8`: keyboard character strobe.
- `ddr_valid  out  1`, `ddr_data  out  8`, `ddr_ack  in  1`: display output handshake.

## Operation
- MAR/MDR loads act only in IDLE. `ld_mar` and `ld_mdr` asserted while busy are ignored.
- States:
  - IDLE: `mio_en`=1 latches `r_w` and decodes MAR.
    - KBSR xFE00, KBDR xFE02, DSR xFE04 → DONE; access performed on the same edge.
    - DDR xFE06 write with display busy → IOW.
    - DDR write with display free → DONE.
    - Any other address → MEM.
  - MEM: `mem_req`=1, `mem_addr`=MAR, `mem_we`=latched `r_w`, `mem_wdata`=MDR.
    - On `mem_ack`: a read loads MDR←`mem_rdata`; then → DONE.
  - IOW: waits for display free, then performs the DDR write → DONE.
  - DONE: `ready`=1 for one cycle → IDLE.
- Wait counter: cleared on entry to MEM or IOW. Reaching `WAIT_MAX` aborts → DONE with `err`=1. An aborted read sets MDR=x0000.
- Keyboard:
  - `kb_valid` with kb_full=0 loads kbdr←`kb_data` and sets kb_full.
  - `kb_valid` with kb_full=1 is dropped.
- IO reads load MDR as follows:
  - KBSR = {kb_full,15'b0}.
  - KBDR = {8'h00,kbdr}; the read clears kb_full.
  - DSR = {~ddr_valid,15'b0}.
  - DDR = x0000.
- IO writes:
  - Writes to KBSR, KBDR and DSR are ignored but still complete normally.
  - A DDR write sets `ddr_data`←MDR[7:0] and `ddr_valid`=1.
  - `ddr_valid` clears on the edge where `ddr_ack`=1.
- Simultaneous `kb_valid` and KBDR read with kb_full=1: MDR gets the old char, the new char is loaded, and kb_full stays 1 (set wins).
- Simultaneous `ddr_ack` and DDR write: the write wins and `ddr_valid` stays 1 with the new data.
- `mem_ack` outside MEM is ignored.

## Timing
- Reset values:
  - MAR = x0000, MDR = x0000.
  - `ready`, `err`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata` = x0000.
  - `ddr_valid` = 0, `ddr_data` = x00.
  - kb_full = 0.
  - State = IDLE, wait counter = 0.
- Reset mid-access: IDLE on the next edge and `mem_req` low from that cycle. No `ready` pulse for the aborted access.
- All outputs are registered.
- Memory access, with `mio_en` sampled at edge 0:
  - `mem_req` is high in cycle 1.
  - `mem_ack` sampled high in cycle n gives MDR valid and `ready`=1 in cycle n+1.
  - Minimum latency is 2 cycles.
- IO access: `ready` in cycle 1, with MDR valid in that cycle.
- `mem_req` stays high until the ack edge and drops in DONE. Only one request is outstanding at a time.
- `err` is asserted only together with `ready`.
- `ready` is never high on two consecutive cycles. A new access may start in the cycle after DONE.

## Test plan
- Memory read, MAR=x3000, `mem_ack` 3 cycles after `mem_req`, `mem_rdata`=xBEEF → MDR=xBEEF, `ready` pulse 1 cycle after ack, `err`=0.
- Memory write, MDR=x1234 at MAR=x4000 → `mem_we`=1, `mem_wdata`=x1234, `mem_addr`=x4000 held until ack.
- Keyboard: `kb_valid` with `kb_data`=x41 → KBSR read gives x8000, KBDR read gives x0041, then KBSR read gives x0000. A second `kb_valid` while full is dropped.
- Display: DDR write x0058 → `ddr_valid`=1, `ddr_data`=x58, DSR read gives x0000. A second DDR write stalls in IOW until `ddr_ack`, then completes.
- Timeout: `WAIT_MAX`=4, no `mem_ack` on a read → `ready` and `err` high, MDR=x0000, `mem_req` low afterward.
- Reset asserted in MEM → `mem_req` low next cycle, no `ready`, and a following read at x3001 completes normally.
